// File: rtl/sd_spi_pkg.sv
// Shared constants and types for the SPI-mode SD card responder.
package sd_spi_pkg;

  localparam int unsigned Cmd0  = 0;
  localparam int unsigned Cmd8  = 8;
  localparam int unsigned Cmd41 = 41;
  localparam int unsigned Cmd55 = 55;

  localparam logic [2:0] R1IdleBit    = 3'd0;
  localparam logic [2:0] R1IllegalBit = 3'd2;
  localparam logic [2:0] R1CrcBit     = 3'd3;

  localparam logic [3:0] VhsCheck = 4'h1;

  typedef enum logic [2:0] {StIdle, StHunt, StRx, StDecode, StNcr, StTx} state_e;
  typedef enum logic [1:0] {ModePwr, ModeIdle, ModeReady} mode_e;

  function automatic logic [7:0] r1_bit(input logic [2:0] pos);
    logic [7:0] r;
    r = 8'h00;
    r[pos] = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] r1_with_idle(input logic [7:0] base, input logic idle);
    logic [7:0] r;
    r = base;
    r[R1IdleBit] = r[R1IdleBit] | idle;
    return r;
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB-first; used only when SD_CRC_CHECK_EN is defined.
module sd_crc7 (
  input  logic       clk_ref,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       bit_en,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic [6:0] crc_q;
  logic       fb;

  assign fb  = bit_in ^ crc_q[6];
  assign crc = crc_q;

  always_ff @(posedge clk_ref) begin
    if (!rst_n) begin
      crc_q <= 7'd0;
    end else if (clear) begin
      crc_q <= 7'd0;
    end else if (bit_en) begin
      crc_q <= {crc_q[5:3], crc_q[2] ^ fb, crc_q[1:0], fb};
    end
  end

endmodule

// File: rtl/sd_spi_card_resp.sv
// SPI-mode SD card responder: decodes host command frames and answers R1/R7 on sd_miso.
// Optional CRC7 checking of CMD0/CMD8 is enabled by defining SD_CRC_CHECK_EN.
module sd_spi_card_resp
  import sd_spi_pkg::*;
#(
  parameter int unsigned ACMD41_BUSY_CNT = 3,
  parameter int unsigned NCR_BYTES       = 1,
  parameter int unsigned CMD_IDX_W       = 6
) (
  input  logic                 clk_ref,
  input  logic                 rst_n,
  input  logic                 sd_clk,
  input  logic                 sd_cs,
  input  logic                 sd_mosi,
  output logic                 sd_miso,
  output logic                 card_ready,
  output logic                 cmd_strobe,
  output logic [CMD_IDX_W-1:0] cmd_index,
  output logic [31:0]          cmd_arg
);

  localparam int unsigned BusyW   = (ACMD41_BUSY_CNT == 0) ? 1 : $clog2(ACMD41_BUSY_CNT + 1);
  localparam int unsigned NcrBits = NCR_BYTES * 8;

  logic [2:0] sclk_sync_q;
  logic [1:0] cs_sync_q, mosi_sync_q;
  logic       sclk_rise, sclk_fall, cs_s, mosi_s;

  always_ff @(posedge clk_ref) begin
    if (!rst_n) begin
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b11;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], sd_clk};
      cs_sync_q   <= {cs_sync_q[0], sd_cs};
      mosi_sync_q <= {mosi_sync_q[0], sd_mosi};
    end
  end

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_s      = cs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];

  state_e               state_q;
  mode_e                mode_q, mode_d;
  logic [45:0]          frame_q;  // frame bits 45..0; bit 47 is the start bit
  logic [5:0]           bit_cnt_q;
  logic [39:0]          resp_q;
  logic [5:0]           resp_len_q;
  logic [5:0]           ncr_cnt_q;
  logic                 app_cmd_q, app_cmd_d;
  logic [BusyW-1:0]     busy_q, busy_d;
  logic                 ready_q, ready_d;
  logic                 strobe_q, miso_q;
  logic [CMD_IDX_W-1:0] cmd_index_q;
  logic [31:0]          cmd_arg_q;

  logic [CMD_IDX_W-1:0] idx;
  logic [31:0]          arg;
  logic                 idle, crc_bad, dec_silent;
  logic                 is_cmd0, is_cmd8, is_cmd41, is_cmd55;
  logic [39:0]          dec_resp;
  logic [5:0]           dec_len;

  assign idx      = frame_q[40 +: CMD_IDX_W];
  assign arg      = frame_q[39:8];
  assign idle     = (mode_q == ModeIdle);
  assign is_cmd0  = (idx == CMD_IDX_W'(Cmd0));
  assign is_cmd8  = (idx == CMD_IDX_W'(Cmd8));
  assign is_cmd41 = (idx == CMD_IDX_W'(Cmd41));
  assign is_cmd55 = (idx == CMD_IDX_W'(Cmd55));

`ifdef SD_CRC_CHECK_EN
  logic [6:0] crc;

  // The start bit is always 0, so a CRC cleared during HUNT already covers it.
  sd_crc7 u_crc7 (
    .clk_ref (clk_ref),
    .rst_n   (rst_n),
    .clear   (state_q == StHunt),
    .bit_en  (sclk_rise && (state_q == StRx) && (bit_cnt_q < 6'd40)),
    .bit_in  (mosi_s),
    .crc     (crc)
  );

  assign crc_bad = (is_cmd0 || is_cmd8) && (crc != frame_q[7:1]);
`else
  assign crc_bad = 1'b0;
`endif

  always_comb begin
    dec_silent = 1'b0;
    dec_resp   = 40'd0;
    dec_len    = 6'd8;
    mode_d     = mode_q;
    app_cmd_d  = 1'b0;
    busy_d     = busy_q;
    ready_d    = ready_q;
    if (is_cmd0) begin
      if (crc_bad) begin
        dec_resp = {r1_with_idle(r1_bit(R1CrcBit), idle), 32'd0};
      end else begin
        mode_d   = ModeIdle;
        busy_d   = '0;
        ready_d  = 1'b0;
        dec_resp = {r1_bit(R1IdleBit), 32'd0};
      end
    end else if (mode_q == ModePwr) begin
      dec_silent = 1'b1;
      app_cmd_d  = app_cmd_q;
    end else if (is_cmd8 && crc_bad) begin
      dec_resp = {r1_with_idle(r1_bit(R1CrcBit), idle), 32'd0};
    end else if (is_cmd8 && (arg[11:8] == VhsCheck)) begin
      dec_resp = {r1_with_idle(8'h00, idle), 8'h00, 8'h00, 8'h01, arg[7:0]};
      dec_len  = 6'd40;
    end else if (is_cmd55) begin
      app_cmd_d = 1'b1;
      dec_resp  = {r1_with_idle(8'h00, idle), 32'd0};
    end else if (is_cmd41 && app_cmd_q) begin
      if (busy_q < BusyW'(ACMD41_BUSY_CNT)) begin
        dec_resp = {r1_bit(R1IdleBit), 32'd0};
        busy_d   = busy_q + 1'b1;
      end else begin
        dec_resp = 40'd0;
        mode_d   = ModeReady;
        ready_d  = 1'b1;
      end
    end else begin
      dec_resp = {r1_with_idle(r1_bit(R1IllegalBit), idle), 32'd0};
    end
  end

  always_ff @(posedge clk_ref) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mode_q      <= ModePwr;
      frame_q     <= '0;
      bit_cnt_q   <= '0;
      resp_q      <= '0;
      resp_len_q  <= 6'd8;
      ncr_cnt_q   <= '0;
      app_cmd_q   <= 1'b0;
      busy_q      <= '0;
      ready_q     <= 1'b0;
      strobe_q    <= 1'b0;
      miso_q      <= 1'b1;
      cmd_index_q <= '0;
      cmd_arg_q   <= '0;
    end else begin
      strobe_q <= 1'b0;
      if (cs_s) begin
        state_q <= StIdle;
        miso_q  <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: state_q <= StHunt;
          StHunt: begin
            if (sclk_rise && !mosi_s) begin
              frame_q   <= '0;
              bit_cnt_q <= 6'd1;
              state_q   <= StRx;
            end
          end
          StRx: begin
            if (sclk_rise) begin
              frame_q   <= {frame_q[44:0], mosi_s};
              bit_cnt_q <= bit_cnt_q + 6'd1;
              // Last bit: frame_q[45] still holds the transmission bit.
              if (bit_cnt_q == 6'd47) begin
                state_q <= (frame_q[45] && mosi_s) ? StDecode : StHunt;
              end
            end
          end
          StDecode: begin
            mode_q    <= mode_d;
            app_cmd_q <= app_cmd_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            if (dec_silent) begin
              state_q <= StHunt;
            end else begin
              strobe_q    <= 1'b1;
              cmd_index_q <= idx;
              cmd_arg_q   <= arg;
              resp_q      <= dec_resp;
              resp_len_q  <= dec_len;
              ncr_cnt_q   <= '0;
              bit_cnt_q   <= '0;
              state_q     <= StNcr;
            end
          end
          StNcr: begin
            if (sclk_fall) begin
              if (ncr_cnt_q == 6'(NcrBits - 1)) begin
                state_q <= StTx;
              end else begin
                ncr_cnt_q <= ncr_cnt_q + 6'd1;
              end
            end
          end
          StTx: begin
            if (sclk_fall) begin
              if (bit_cnt_q == resp_len_q) begin
                miso_q  <= 1'b1;
                state_q <= StHunt;
              end else begin
                miso_q    <= resp_q[39];
                resp_q    <= {resp_q[38:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 6'd1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign sd_miso    = miso_q;
  assign card_ready = ready_q;
  assign cmd_strobe = strobe_q;
  assign cmd_index  = cmd_index_q;
  assign cmd_arg    = cmd_arg_q;

endmodule

// File: tb/tb_sd_spi_card_resp.sv
// Host-side bench for sd_spi_card_resp: drives command frames, scoreboards strobes and responses.
module tb_sd_spi_card_resp;

  localparam int H = 6;  // sd_clk half period in clk_ref cycles

  logic        clk_ref = 1'b0;
  logic        rst_n   = 1'b0;
  logic        sd_clk  = 1'b0;
  logic        sd_cs   = 1'b1;
  logic        sd_mosi = 1'b1;
  logic        sd_miso, card_ready, cmd_strobe;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;

  always #5 clk_ref = ~clk_ref;

  sd_spi_card_resp #(
    .ACMD41_BUSY_CNT (3),
    .NCR_BYTES       (1),
    .CMD_IDX_W       (6)
  ) dut (
    .clk_ref    (clk_ref),
    .rst_n      (rst_n),
    .sd_clk     (sd_clk),
    .sd_cs      (sd_cs),
    .sd_mosi    (sd_mosi),
    .sd_miso    (sd_miso),
    .card_ready (card_ready),
    .cmd_strobe (cmd_strobe),
    .cmd_index  (cmd_index),
    .cmd_arg    (cmd_arg)
  );

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
  } strb_t;

  typedef struct {
    int          len;
    logic [39:0] val;
    bit          partial;
  } resp_t;

  strb_t exp_strb_q[$];
  resp_t exp_resp_q[$];

  int n_checks   = 0;
  int n_fail     = 0;
  int rise_cnt   = 0;
  int last_end   = 0;
  int resp_cnt   = 0;
  int strobe_cnt = 0;

  localparam logic [47:0] FCmd0    = 48'h40_00000000_95;
  localparam logic [47:0] FCmd0Bad = 48'h40_00000000_97;
  localparam logic [47:0] FCmd8    = 48'h48_000001AA_87;
  localparam logic [47:0] FCmd8Vhs = 48'h48_000002AA_FF;
  localparam logic [47:0] FStop0   = 48'h48_000001AA_86;
  localparam logic [47:0] FTbit0   = 48'h08_000001AA_87;
  localparam logic [47:0] FCmd17   = 48'h51_00000000_FF;
  localparam logic [47:0] FCmd41   = 48'h69_40000000_FF;
  localparam logic [47:0] FCmd55   = 48'h77_00000000_FF;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Strobe monitor.
  strb_t s_cur;
  always @(negedge clk_ref) begin
    if (rst_n && cmd_strobe === 1'b1) begin
      strobe_cnt++;
      if (exp_strb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got index %0d, expected no strobe", cmd_index);
      end else begin
        s_cur = exp_strb_q.pop_front();
        check("cmd_index", 40'(cmd_index), 40'(s_cur.idx));
        check("cmd_arg", 40'(cmd_arg), 40'(s_cur.arg));
      end
    end
  end

  // Response monitor: a response begins at the first 0 sampled on miso.
  resp_t       r_cur;
  bit          collecting = 1'b0;
  int          nbits;
  logic [39:0] got;
  always @(posedge sd_clk or posedge sd_cs) begin
    if (sd_cs) begin
      if (collecting) begin
        collecting = 1'b0;
        if (r_cur.partial) begin
          check("resp_prefix", got, r_cur.val >> (r_cur.len - nbits));
        end else begin
          n_checks++;
          n_fail++;
          $display("FAIL resp_truncated: got %0d bits, expected %0d", nbits, r_cur.len);
        end
      end
    end else if (collecting) begin
      got = {got[38:0], sd_miso};
      nbits++;
      if (nbits == r_cur.len) begin
        collecting = 1'b0;
        check("resp_value", got, r_cur.val);
      end
    end else if (sd_miso === 1'b0) begin
      resp_cnt++;
      if (exp_resp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got miso 0 at rise %0d, expected idle 1", rise_cnt);
      end else begin
        r_cur = exp_resp_q.pop_front();
        check("ncr_gap", 40'(rise_cnt - last_end), 40'd9);
        got        = 40'd0;
        nbits      = 1;
        collecting = 1'b1;
      end
    end
  end

  task automatic sd_bit(input logic b);
    sd_mosi = b;
    repeat (H) @(negedge clk_ref);
    rise_cnt++;
    sd_clk = 1'b1;
    repeat (H) @(negedge clk_ref);
    sd_clk = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) sd_bit(f[i]);
    last_end = rise_cnt;
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) sd_bit(1'b1);
  endtask

  task automatic expect_txn(input logic [47:0] f, input int len, input logic [39:0] val,
                            input bit partial);
    strb_t s;
    resp_t r;
    s.idx     = f[45:40];
    s.arg     = f[39:8];
    r.len     = len;
    r.val     = val;
    r.partial = partial;
    exp_strb_q.push_back(s);
    exp_resp_q.push_back(r);
  endtask

  task automatic txn(input logic [47:0] f, input int len, input logic [39:0] val);
    expect_txn(f, len, val, 1'b0);
    send_frame(f);
    idle_bits(64);
  endtask

  task automatic txn_silent(input logic [47:0] f, input string name);
    int s0, r0;
    s0 = strobe_cnt;
    r0 = resp_cnt;
    send_frame(f);
    idle_bits(64);
    check({name, "_strobes"}, 40'(strobe_cnt), 40'(s0));
    check({name, "_resps"}, 40'(resp_cnt), 40'(r0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (5) @(negedge clk_ref);
    check("rst_miso", 40'(sd_miso), 40'd1);
    check("rst_card_ready", 40'(card_ready), 40'd0);
    check("rst_cmd_strobe", 40'(cmd_strobe), 40'd0);
    check("rst_cmd_index", 40'(cmd_index), 40'd0);
    check("rst_cmd_arg", 40'(cmd_arg), 40'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_ref);
    sd_cs = 1'b0;
    repeat (5) @(negedge clk_ref);
    idle_bits(8);

    txn_silent(FCmd8, "pwr_cmd8");
`ifdef SD_CRC_CHECK_EN
    txn(FCmd0Bad, 8, 40'h08);
`else
    txn(FCmd0Bad, 8, 40'h01);
`endif
    txn(FCmd0, 8, 40'h01);
    check("ready_after_cmd0", 40'(card_ready), 40'd0);
    txn_silent(FStop0, "stop_bit0");
    txn_silent(FTbit0, "tx_bit0");
    txn(FCmd8, 40, 40'h01_0000_01AA);
`ifdef SD_CRC_CHECK_EN
    txn(FCmd8Vhs, 8, 40'h09);
`else
    txn(FCmd8Vhs, 8, 40'h05);
`endif
    txn(FCmd17, 8, 40'h05);
    txn(FCmd41, 8, 40'h05);

    for (int i = 0; i < 4; i++) begin
      txn(FCmd55, 8, 40'h01);
      txn(FCmd41, 8, (i < 3) ? 40'h01 : 40'h00);
      check("ready_acmd41", 40'(card_ready), (i == 3) ? 40'd1 : 40'd0);
    end
    txn(FCmd55, 8, 40'h00);
    txn(FCmd8, 40, 40'h00_0000_01AA);
    txn(FCmd41, 8, 40'h04);

    // Release chip select while the R7 is mid-flight.
    expect_txn(FCmd8, 40, 40'h00_0000_01AA, 1'b1);
    send_frame(FCmd8);
    idle_bits(20);
    repeat (5) @(negedge clk_ref);
    check("miso_before_release", 40'(sd_miso), 40'd0);
    sd_cs = 1'b1;
    repeat (3) @(posedge clk_ref);
    #1;
    check("miso_after_release", 40'(sd_miso), 40'd1);
    repeat (10) @(negedge clk_ref);
    sd_cs = 1'b0;
    repeat (5) @(negedge clk_ref);
    idle_bits(8);
    txn(FCmd8, 40, 40'h00_0000_01AA);

    txn(FCmd0, 8, 40'h01);
    check("ready_after_reinit", 40'(card_ready), 40'd0);

    repeat (50) @(negedge clk_ref);
    check("resp_queue_drained", 40'(exp_resp_q.size()), 40'd0);
    check("strobe_queue_drained", 40'(exp_strb_q.size()), 40'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
